// File: rtl/imem_loader.sv
// Boot-time loader: byte stream -> little-endian 32-bit words -> instruction memory writes.
// Optional trailing XOR checksum is built when IMEM_LOADER_CSUM_EN is defined.
module imem_loader #(
    parameter logic [63:0] ADDR_BASE = 64'd0,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [63:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int unsigned COUNT_W = 16;
    localparam int unsigned LANE_W  = 2;

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state;
    logic [LANE_W-1:0]    lane;
    logic [COUNT_W-1:0]   index;
    logic [COUNT_W-1:0]   word_count;
    logic [7:0]           cnt_lo;
    logic [23:0]          word_buf;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]           csum;
`endif

    logic                 xfer;
    logic [COUNT_W-1:0]   hdr_count;
    logic                 hdr_too_big;
    logic                 last_word;
    logic [63:0]          word_addr;

    // Ready is gated by reset directly so no byte is taken while reset is held.
    assign byte_ready  = !reset && (state == S_HDR_LO || state == S_HDR_HI ||
                                    state == S_DATA   || state == S_CSUM);
    assign xfer        = byte_valid && byte_ready;
    assign hdr_count   = {byte_data, cnt_lo};
    assign hdr_too_big = 32'(hdr_count) > MAX_WORDS;
    assign last_word   = (index == word_count - COUNT_W'(1));
    assign word_addr   = ADDR_BASE + {46'd0, index, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_HDR_LO;
            lane       <= '0;
            index      <= '0;
            word_count <= '0;
            cnt_lo     <= '0;
            word_buf   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum       <= '0;
`endif
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_HDR_LO: begin
                    if (xfer) begin
                        cnt_lo <= byte_data;
                        state  <= S_HDR_HI;
                    end
                end

                S_HDR_HI: begin
                    if (xfer) begin
                        word_count <= hdr_count;
                        lane       <= '0;
                        index      <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        csum       <= '0;
`endif
                        if (hdr_too_big) begin
                            state    <= S_ERROR;
                            load_err <= 1'b1;
                        end else if (hdr_count == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
                            state     <= S_CSUM;
`else
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
`ifdef IMEM_LOADER_CSUM_EN
                        csum <= csum ^ byte_data;
`endif
                        lane <= lane + LANE_W'(1);
                        case (lane)
                            2'd0: word_buf[7:0]   <= byte_data;
                            2'd1: word_buf[15:8]  <= byte_data;
                            2'd2: word_buf[23:16] <= byte_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_addr;
                                imem_wdata <= {byte_data, word_buf};
                                index      <= index + COUNT_W'(1);
                                if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                                    state     <= S_CSUM;
`else
                                    state     <= S_DONE;
                                    load_done <= 1'b1;
                                    core_hold <= 1'b0;
`endif
                                end
                            end
                        endcase
                    end
                end

`ifdef IMEM_LOADER_CSUM_EN
                S_CSUM: begin
                    if (xfer) begin
                        if (byte_data == csum) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state    <= S_ERROR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE, S_ERROR: begin
                    if (restart) begin
                        state     <= S_HDR_LO;
                        lane      <= '0;
                        index     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        csum      <= '0;
`endif
                        core_hold <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_HDR_LO;
                    core_hold <= 1'b1;
                    load_done <= 1'b0;
                    load_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and checked when imem_we fires. Works with or without IMEM_LOADER_CSUM_EN.
module tb_imem_loader;

    localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam int unsigned MAXW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        restart;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int n_expected = 0;
    logic         prev_we = 1'b0;
    logic [95:0]  exp_q[$];
    logic [31:0]  img[$];

    imem_loader #(.ADDR_BASE(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .restart(restart), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_hold(core_hold),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write monitor: samples 2ns after each rising edge.
    always @(posedge clk) begin
        #2;
        if (imem_we === 1'b1) begin
            logic [95:0] e;
            n_writes++;
            check("we_one_cycle", 64'(prev_we), 64'd0);
            check("write_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", imem_addr, e[95:32]);
                check("wr_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
        prev_we = imem_we;
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("byte_ready_timeout", 64'(byte_ready), 64'd1);
        @(negedge clk);
    endtask

    // Sends header, the words in img, and (if built) the checksum xored with csum_xor.
    task automatic send_image(input bit gaps, input logic [7:0] csum_xor);
        logic [7:0]  bytes[$];
        logic [7:0]  cs;
        logic [15:0] n;
        logic [31:0] w;
        n  = 16'(img.size());
        cs = 8'h00;
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) begin
                bytes.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
`ifdef IMEM_LOADER_CSUM_EN
        bytes.push_back(cs ^ csum_xor);
`else
        if (csum_xor != 8'h00) cs = 8'h00;
`endif
        for (int i = 0; i < bytes.size(); i++) begin
            if (i % 4 == 1 && i > 1 && (i - 2) / 4 < img.size()) begin
                exp_q.push_back({BASE + 64'(4 * ((i - 2) / 4)), img[(i - 2) / 4]});
                n_expected++;
            end
            if (i == bytes.size() - 1) begin
                check("done_early", 64'(load_done), 64'd0);
                check("err_early", 64'(load_err), 64'd0);
            end
            send_byte(bytes[i], gaps);
        end
        byte_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, 64'(load_done), 64'd1);
        check({tag, "_err"}, 64'(load_err), 64'd0);
        check({tag, "_hold"}, 64'(core_hold), 64'd0);
        check({tag, "_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic expect_err(input string tag);
        check({tag, "_err"}, 64'(load_err), 64'd1);
        check({tag, "_done"}, 64'(load_done), 64'd0);
        check({tag, "_hold"}, 64'(core_hold), 64'd1);
        check({tag, "_ready"}, 64'(byte_ready), 64'd0);
    endtask

    task automatic expect_reset_state(input string tag);
        check({tag, "_we"}, 64'(imem_we), 64'd0);
        check({tag, "_addr"}, imem_addr, 64'd0);
        check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, "_hold"}, 64'(core_hold), 64'd1);
        check({tag, "_done"}, 64'(load_done), 64'd0);
        check({tag, "_err"}, 64'(load_err), 64'd0);
        check({tag, "_ready"}, 64'(byte_ready), 64'd1);
    endtask

    initial begin
        reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; restart = 1'b0;
        repeat (3) @(negedge clk);
        check("ready_in_reset", 64'(byte_ready), 64'd0);
        reset = 1'b0;
        #1;
        expect_reset_state("rst");
        @(negedge clk);

        // Two-word good image
        img = '{32'h0000_0013, 32'h0010_0093};
        send_image(1'b0, 8'h00);
        expect_done("good2");

        // Empty image
        do_restart();
        img.delete();
        send_image(1'b0, 8'h00);
        expect_done("empty");

        // Oversize headers, one just past the limit and one via the high byte
        do_restart();
        send_byte(8'(MAXW + 1), 1'b0);
        send_byte(8'h00, 1'b0);
        byte_valid = 1'b0;
        expect_err("over9");
        do_restart();
        check("restart_clears_err", 64'(load_err), 64'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        byte_valid = 1'b0;
        expect_err("over256");

        // Exactly MAX_WORDS words; addresses wrap past 2^64
        do_restart();
        img.delete();
        for (int i = 0; i < MAXW; i++) img.push_back($urandom());
        send_image(1'b0, 8'h00);
        expect_done("max");

`ifdef IMEM_LOADER_CSUM_EN
        // Bad checksum: the write still happens, then error
        do_restart();
        img = '{32'hDEAD_BEEF};
        send_image(1'b0, 8'h01);
        expect_err("badcs");
        check("badcs_pending", 64'(exp_q.size()), 64'd0);
`endif

        // Reset after two payload bytes of a word
        do_restart();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_ready", 64'(byte_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        expect_reset_state("midrst");
        @(negedge clk);
        img = '{32'h1234_5678};
        send_image(1'b0, 8'h00);
        expect_done("after_rst");

        // Four words with random valid gaps
        do_restart();
        img = '{32'h0000_0013, 32'h0010_0093, 32'hCAFE_F00D, 32'h8000_0001};
        send_image(1'b1, 8'h00);
        expect_done("gaps");

        // Restart while a byte is offered: it must not be taken as a count byte
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        @(negedge clk);
        check("done_holds_ready", 64'(byte_ready), 64'd0);
        do_restart();
        byte_valid = 1'b0;
        check("restart_done_clr", 64'(load_done), 64'd0);
        check("restart_ready", 64'(byte_ready), 64'd1);
        img = '{32'h0BAD_CAFE, 32'h7777_0000};
        send_image(1'b1, 8'h00);
        expect_done("restart_valid");

        repeat (3) @(negedge clk);
        check("write_count", 64'(n_writes), 64'(n_expected));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
